// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Initiator-side controller for a word-wide, byte-addressed data memory.
//   Turns lb/lbu/lh/lhu/lw/sb/sh/sw requests into aligned word accesses.
//   Sub-word stores are done as read-modify-write (RD then WR).
//
//   Optional feature macro: MEM_MISALIGN_TRAP_EN
//     defined   : misaligned half/word and size 11 complete at once with err_o
//                 and no memory cycle.
//     undefined : err_o is always 0, offending low address bits are ignored,
//                 and size 11 behaves as a word access.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-low reset
//   req_i                 request valid (sampled in IDLE only)
//   we_i, size_i          store/load, 00 byte / 01 half / 10 word / 11 reserved
//   unsigned_i            zero-extend (1) or sign-extend (0) load data
//   addr_i, wdata_i       byte address, right-justified store data
//   busy_o, done_o        in flight, one-cycle completion pulse
//   rdata_o, err_o        extended load data, misalignment flag
//   mem_addr_o            word-aligned memory address
//   mem_data_o            merged write word
//   mem_read_o            memory read enable
//   mem_write_o           memory write enable
//   mem_data_i            memory read data (combinational from mem_addr_o)
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              misalign;
    logic [4:0]        byte_sh, half_sh;
    logic [DATA_W-1:0] rd_byte, rd_half, load_val, merged;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = (size_i == 2'b01 && addr_i[0]) ||
                      (size_i == 2'b10 && addr_i[1:0] != 2'b00) ||
                      (size_i == 2'b11);
`else
    assign misalign = 1'b0;
`endif

    // Lane shift amounts; halfword uses only addr[1], so a stray addr[0]
    // is ignored when the trap is not built in.
    assign byte_sh = {lane_q, 3'b000};
    assign half_sh = {lane_q[1], 4'b0000};

    assign rd_byte = mem_data_i >> byte_sh;
    assign rd_half = mem_data_i >> half_sh;

    always_comb begin
        load_val = mem_data_i;
        merged   = wdata_q;
        case (size_q)
            2'b00: begin
                load_val = {{(DATA_W-8){~uns_q & rd_byte[7]}}, rd_byte[7:0]};
                merged   = (mem_data_i & ~(DATA_W'(8'hFF) << byte_sh)) |
                           (DATA_W'(wdata_q[7:0]) << byte_sh);
            end
            2'b01: begin
                load_val = {{(DATA_W-16){~uns_q & rd_half[15]}}, rd_half[15:0]};
                merged   = (mem_data_i & ~(DATA_W'(16'hFFFF) << half_sh)) |
                           (DATA_W'(wdata_q[15:0]) << half_sh);
            end
            default: begin
                load_val = mem_data_i;
                merged   = wdata_q;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        lane_d     = lane_q;
        wdata_d    = wdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    we_d       = we_i;
                    size_d     = size_i;
                    uns_d      = unsigned_i;
                    lane_d     = addr_i[1:0];
                    wdata_d    = wdata_i;
                    mem_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
                    // A word store needs no read; its write word is ready now.
                    mem_data_d = wdata_i;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (we_i && size_i[1]) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_data_d = merged;
                    state_d    = WR;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            default: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            lane_q     <= lane_d;
            wdata_q    <= wdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode straight from the state register.
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == RESP);
    assign mem_read_o  = (state_q == RD);
    assign mem_write_o = (state_q == WR);
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_data_o  = mem_data_q;

endmodule
